// File: rtl/bip_control_unit.sv
// bip_control_unit: fetch/decode/execute sequencer for the accumulator CPU.
// Optional macro BIP_CONTROL_INSTR_CNT_EN adds o_instr_cnt, a saturating count of retired instructions.
module bip_control_unit #(
   parameter int PC_WIDTH     = 11,
   parameter int OPCODE_WIDTH = 5,
   parameter int INSTR_WIDTH  = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic [INSTR_WIDTH-1:0] i_instr,
   output logic [PC_WIDTH-1:0]    o_pc,
   output logic [PC_WIDTH-1:0]    o_signal,
   output logic [1:0]             o_selA,
   output logic                   o_selB,
   output logic                   o_WrAcc,
   output logic                   o_OP,
   output logic                   o_WrRam,
   output logic                   o_RdRam,
   output logic                   o_busy,
   output logic                   o_halt
`ifdef BIP_CONTROL_INSTR_CNT_EN
   ,
   output logic [15:0]            o_instr_cnt
`endif
);
   typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;
   localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = 5'b00000;
   localparam logic [OPCODE_WIDTH-1:0] OP_STO  = 5'b00001;
   localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 5'b00010;
   localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 5'b00011;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'b00100;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 5'b00101;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 5'b00110;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 5'b00111;

   state_t                  state_q, state_d;
   logic [PC_WIDTH-1:0]     pc_q, pc_d;
   logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
   logic [OPCODE_WIDTH-1:0] opc, ir_opc;

   // Next-state, PC/IR update and combinational control decode.
   always_comb begin
      opc      = i_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
      ir_opc   = ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      o_pc     = pc_q;
      o_signal = '0;
      o_selA   = 2'b00;
      o_selB   = 1'b0;
      o_WrAcc  = 1'b0;
      o_OP     = 1'b0;
      o_WrRam  = 1'b0;
      o_RdRam  = 1'b0;
      o_busy   = state_q inside {FETCH, EXEC, MEM};
      o_halt   = state_q == HALT;
      case (state_q)
         IDLE:  state_d = i_start ? FETCH : IDLE;
         FETCH: state_d = EXEC;
         EXEC: begin
            ir_d     = i_instr;
            o_signal = i_instr[PC_WIDTH-1:0];
            state_d  = FETCH;
            pc_d     = pc_q + PC_WIDTH'(1);
            case (opc)
               OP_HLT: begin
                  state_d = HALT;
                  pc_d    = pc_q;
               end
               OP_STO: o_WrRam = 1'b1;
               OP_LD, OP_ADD, OP_SUB: begin
                  o_RdRam = 1'b1;
                  state_d = MEM;
                  pc_d    = pc_q;
               end
               OP_LDI: begin
                  o_selA  = 2'b01;
                  o_WrAcc = 1'b1;
               end
               OP_ADDI, OP_SUBI: begin
                  o_selA  = 2'b10;
                  o_selB  = 1'b1;
                  o_OP    = opc == OP_SUBI;
                  o_WrAcc = 1'b1;
               end
               default: ;
            endcase
         end
         MEM: begin
            o_signal = ir_q[PC_WIDTH-1:0];
            o_selA   = ir_opc == OP_LD ? 2'b00 : 2'b10;
            o_OP     = ir_opc == OP_SUB;
            o_WrAcc  = 1'b1;
            pc_d     = pc_q + PC_WIDTH'(1);
            state_d  = FETCH;
         end
         HALT: ;
         default: state_d = IDLE;
      endcase
   end

   // State, PC and instruction register; reset wins in every state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

`ifdef BIP_CONTROL_INSTR_CNT_EN
   logic [15:0] cnt_q, cnt_d;
   logic        retire;

   // An instruction retires when control returns to FETCH from EXEC/MEM or HALT is entered.
   always_comb begin
      retire = (state_d == FETCH && state_q inside {EXEC, MEM}) || (state_d == HALT && state_q != HALT);
      cnt_d  = retire && cnt_q != 16'hFFFF ? cnt_q + 16'd1 : cnt_q;
   end

   // Saturating retired-instruction counter.
   always_ff @(posedge i_clk) begin
      if (i_reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end

   assign o_instr_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_bip_control_unit.sv
// tb_bip_control_unit: table, hand-sequence and random-program checks of bip_control_unit.
module tb_bip_control_unit;
   typedef struct packed {
      logic [10:0] pc;
      logic [10:0] sig;
      logic [1:0]  sela;
      logic        selb, wracc, op, wrram, rdram, busy, halt;
   } obs_t;
   typedef struct {
      logic [15:0] instr;
      obs_t        ex;
      obs_t        mem;
      bit          has_mem;
   } vec_t;

   logic        clk = 0, rst = 1, start = 0;
   logic [15:0] instr = '0;
   logic [10:0] o_pc, o_signal;
   logic [1:0]  o_selA;
   logic        o_selB, o_WrAcc, o_OP, o_WrRam, o_RdRam, o_busy, o_halt;
`ifdef BIP_CONTROL_INSTR_CNT_EN
   logic [15:0] o_instr_cnt;
`endif
   logic [15:0] rom [2048];
   obs_t        act;
   obs_t        expq [$];
   vec_t        tbl [6];
   int          errors = 0, checks = 0;

   bip_control_unit dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_instr(instr),
      .o_pc(o_pc), .o_signal(o_signal), .o_selA(o_selA), .o_selB(o_selB),
      .o_WrAcc(o_WrAcc), .o_OP(o_OP), .o_WrRam(o_WrRam), .o_RdRam(o_RdRam),
      .o_busy(o_busy), .o_halt(o_halt)
`ifdef BIP_CONTROL_INSTR_CNT_EN
      , .o_instr_cnt(o_instr_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) instr <= rom[o_pc];
   assign act = {o_pc, o_signal, o_selA, o_selB, o_WrAcc, o_OP, o_WrRam, o_RdRam, o_busy, o_halt};

   function automatic obs_t mk(input logic [10:0] pc, sig, input logic [1:0] sa,
                               input logic sb, wa, op, wr, rd, bz, hl);
      obs_t o;
      o = {pc, sig, sa, sb, wa, op, wr, rd, bz, hl};
      return o;
   endfunction

   task automatic chk(input string nm, input obs_t a, input obs_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, a, e);
      end
   endtask

   task automatic cyc;
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst = 1;
      start = 0;
      cyc;
      rst = 0;
      chk("reset_idle", act, '0);
   endtask

   task automatic do_start;
      start = 1;
      cyc;
      start = 0;
   endtask

   // Expected per-cycle trace derived instruction by instruction from the ISA rules.
   task automatic gen_trace(input int max_instr);
      logic [10:0] pc;
      logic [4:0]  opc;
      obs_t        f, e, m;
      pc = 0;
      expq.delete();
      for (int n = 0; n < max_instr; n++) begin
         opc = rom[pc][15:11];
         f = mk(pc, 0, 0, 0, 0, 0, 0, 0, 1, 0);
         expq.push_back(f);
         e = f;
         e.sig = rom[pc][10:0];
         if (opc == 0) begin
            expq.push_back(e);
            repeat (4) expq.push_back(mk(pc, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            return;
         end
         m = e;
         m.wracc = 1;
         if (opc == 1) e.wrram = 1;
         else if (opc inside {2, 4, 6}) begin
            e.rdram = 1;
            m.sela = opc == 2 ? 2'd0 : 2'd2;
            m.op = opc == 6;
         end else if (opc == 3) begin
            e.sela = 1;
            e.wracc = 1;
         end else if (opc == 5 || opc == 7) begin
            e.sela = 2;
            e.selb = 1;
            e.op = opc == 7;
            e.wracc = 1;
         end
         expq.push_back(e);
         if (opc inside {2, 4, 6}) expq.push_back(m);
         pc++;
      end
   endtask

   task automatic run_random(input int n_ins);
      for (int i = 0; i < 2048; i++)
         rom[i] = {$urandom_range(0, 2) == 0 ? 5'($urandom_range(8, 31)) : 5'($urandom_range(1, 7)), 11'($urandom)};
      rom[n_ins-1] = {5'd0, 11'($urandom)};
      gen_trace(n_ins);
      do_reset;
      do_start;
      foreach (expq[k]) begin
         chk("rnd_trace", act, expq[k]);
         start = 1'($urandom_range(0, 1));
         cyc;
      end
      start = 0;
   endtask

   initial begin
      int n;
      foreach (rom[i]) rom[i] = 16'h4000;
      tbl[0] = '{16'h1807, mk(0, 7, 1, 0, 1, 0, 0, 0, 1, 0), '0, 0};
      tbl[1] = '{16'h200A, mk(1, 10, 0, 0, 0, 0, 0, 1, 1, 0), mk(1, 10, 2, 0, 1, 0, 0, 0, 1, 0), 1};
      tbl[2] = '{16'h3803, mk(2, 3, 2, 1, 1, 1, 0, 0, 1, 0), '0, 0};
      tbl[3] = '{16'h0805, mk(3, 5, 0, 0, 0, 0, 1, 0, 1, 0), '0, 0};
      tbl[4] = '{16'hF800, mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 0), '0, 0};
      tbl[5] = '{16'h0000, mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 0), '0, 0};
      cyc;
      // Directed program from the table.
      foreach (tbl[i]) rom[i] = tbl[i].instr;
      do_reset;
      cyc;
      chk("idle_no_start", act, '0);
      do_start;
      for (int i = 0; i < 6; i++) begin
         chk("tbl_fetch", act, mk(11'(i), 0, 0, 0, 0, 0, 0, 0, 1, 0));
         cyc;
         chk("tbl_exec", act, tbl[i].ex);
         cyc;
         if (tbl[i].has_mem) begin
            chk("tbl_mem", act, tbl[i].mem);
            cyc;
         end
      end
      chk("halt", act, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      do_start;
      chk("halt_start_ignored", act, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      cyc;
      chk("halt_hold", act, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`ifdef BIP_CONTROL_INSTR_CNT_EN
      checks++;
      if (o_instr_cnt !== 16'd6) begin
         errors++;
         $display("FAIL instr_cnt: got %0d want 6", o_instr_cnt);
      end
`endif
      // Reset while the ADD is in its memory cycle.
      do_reset;
      do_start;
      repeat (4) cyc;
      chk("pre_reset_mem", act, tbl[1].mem);
      rst = 1;
      cyc;
      rst = 0;
      chk("reset_mid_mem", act, '0);
      cyc;
      chk("idle_after_reset", act, '0);
      // PC wrap through a ROM full of NOPs.
      foreach (rom[i]) rom[i] = 16'h4000;
      do_reset;
      do_start;
      n = 0;
      while (!(o_pc == 2047 && o_busy) && n < 5000) begin
         cyc;
         n++;
      end
      if (n >= 5000) begin
         checks++;
         errors++;
         $display("FAIL wrap_timeout: got pc %0d want 2047 within 5000 cycles", o_pc);
      end else begin
         chk("wrap_fetch", act, mk(2047, 0, 0, 0, 0, 0, 0, 0, 1, 0));
         cyc;
         chk("wrap_exec", act, mk(2047, 0, 0, 0, 0, 0, 0, 0, 1, 0));
         cyc;
         chk("wrap_to_zero", act, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      end
      // Random programs against the trace model.
      for (int r = 0; r < 6; r++) run_random(10 + r * 7);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
